// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator core.
// Fetch-stage widths, FSM states and instruction field positions.
package cpu_pkg;

    localparam int PC_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    localparam logic [3:0] OP_HALT = 4'd14;
    localparam logic [3:0] OP_NOP  = 4'd15;

    localparam int TYPE_BIT = 8;
    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 4;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM address/data, decoder fields and strobes.
// master is the fetch stage, slave is the surrounding core.
interface instr_fetch_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);

    logic             Start;
    logic [PC_W-1:0]  StartAddr;
    logic [8:0]       Instr;
    logic             Branch;
    logic             Halt;
    logic             BranchCond;
    logic [PC_W-1:0]  PC;
    logic             TypeBit;
    logic [3:0]       OP;
    logic [3:0]       Operand;
    logic [7:0]       Offset;
    logic             Running;
    logic             Done;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        input  Start, StartAddr, Instr,
        input  Branch, Halt, BranchCond,
        output PC, TypeBit, OP, Operand, Offset,
        output Running, Done, InstrCount
    );

    modport slave (
        output Start, StartAddr, Instr,
        output Branch, Halt, BranchCond,
        input  PC, TypeBit, OP, Operand, Offset,
        input  Running, Done, InstrCount
    );

endinterface

// File: rtl/instr_fetch_pc_next.sv
// Next-PC select: restart, hold, taken branch or increment.
// Arithmetic wraps modulo 2**PC_W.
module pc_next #(
    parameter int PC_W = 10
) (
    input  logic            restart,
    input  logic            hold,
    input  logic            take,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] start_addr,
    input  logic [7:0]      offset,
    output logic [PC_W-1:0] next
);

    logic [PC_W-1:0] offs_ext;

    assign offs_ext = PC_W'($signed(offset));

    always_comb begin
        next = pc + PC_W'(1);
        if (restart)
            next = start_addr;
        else if (hold)
            next = pc;
        else if (take)
            next = pc + offs_ext;
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch/sequencing stage: PC, run/halt FSM, retire counter.
// Instruction fields pass combinationally; forced to NOP outside RUN.
module instr_fetch #(
    parameter int PC_W  = cpu_pkg::PC_W,
    parameter int CNT_W = 16
) (
    input logic        CLK,
    input logic        Reset,
    instr_fetch_if.master bus
);

    import cpu_pkg::*;

    state_t           state;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic [CNT_W-1:0] cnt;
    logic             running_q;
    logic             done_q;
    logic             run;

    assign run = (state == RUN);

    // Outside RUN the PC holds unless Start reloads it.
    pc_next #(.PC_W(PC_W)) u_pc_next (
        .restart    (bus.Start),
        .hold       (!run || bus.Halt),
        .take       (bus.Branch && bus.BranchCond),
        .pc         (pc_q),
        .start_addr (bus.StartAddr),
        .offset     (bus.Instr[7:0]),
        .next       (pc_d)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            pc_q      <= '0;
            cnt       <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (bus.Start) begin
                state     <= RUN;
                cnt       <= '0;
                running_q <= 1'b1;
                done_q    <= 1'b0;
            end else if (run) begin
                if (cnt != '1)
                    cnt <= cnt + CNT_W'(1);
                if (bus.Halt) begin
                    state     <= HALTED;
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign bus.PC         = pc_q;
    assign bus.TypeBit    = running_q & bus.Instr[TYPE_BIT];
    assign bus.OP         = running_q ? bus.Instr[OP_MSB:OP_LSB] : OP_NOP;
    assign bus.Operand    = bus.Instr[3:0];
    assign bus.Offset     = bus.Instr[7:0];
    assign bus.Running    = running_q;
    assign bus.Done       = done_q;
    assign bus.InstrCount = cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: two instances (16- and 4-bit
// counters) share one ROM and are checked against a sequence model.
module tb_instr_fetch;

    import cpu_pkg::*;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       br = 1'b0;
    logic       ha = 1'b0;
    logic       bc = 1'b0;
    logic [9:0] sa = '0;
    logic [8:0] ins = '0;

    always #5 CLK = ~CLK;

    instr_fetch_if #(.PC_W(10), .CNT_W(16)) ifa ();
    instr_fetch_if #(.PC_W(10), .CNT_W(4))  ifb ();

    assign ifa.Start      = start;
    assign ifa.StartAddr  = sa;
    assign ifa.Instr      = ins;
    assign ifa.Branch     = br;
    assign ifa.Halt       = ha;
    assign ifa.BranchCond = bc;
    assign ifb.Start      = start;
    assign ifb.StartAddr  = sa;
    assign ifb.Instr      = ins;
    assign ifb.Branch     = br;
    assign ifb.Halt       = ha;
    assign ifb.BranchCond = bc;

    instr_fetch #(.PC_W(10), .CNT_W(16)) u16 (
        .CLK   (CLK),
        .Reset (rst),
        .bus   (ifa)
    );

    instr_fetch #(.PC_W(10), .CNT_W(4)) u4 (
        .CLK   (CLK),
        .Reset (rst),
        .bus   (ifb)
    );

    typedef struct {
        int         pc;
        int         run;
        int         done;
        int         cnt;
        logic [8:0] ins;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    logic [8:0] rom [1024];
    int         m_st = 0;
    int         m_pc = 0;
    int         m_cnt = 0;

    task automatic chk(string n, int a, int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
        end
    endtask

    // One clock: present ROM word at the model PC, step the model.
    task automatic cyc(bit r, bit s, int a, bit b_c, bit both = 1'b0);
        exp_t e;
        int   off;
        @(negedge CLK);
        ins   = rom[m_pc];
        br    = ins[8] | both;
        ha    = (!ins[8] && ins[7:4] == OP_HALT) | both;
        bc    = b_c;
        start = s;
        sa    = a[9:0];
        if (r && !rst) begin
            rst = 1'b1;
            #1;
            chk("async_pc", int'(ifa.PC), 0);
            chk("async_running", int'(ifa.Running), 0);
            chk("async_op", int'(ifa.OP), 15);
        end else begin
            rst = r;
        end
        off = int'($signed(ins[7:0]));
        if (r) begin
            m_st = 0; m_pc = 0; m_cnt = 0;
        end else if (m_st == 1) begin
            if (s) begin
                m_pc = a; m_cnt = 0;
            end else begin
                m_cnt++;
                if (ha)
                    m_st = 2;
                else if (br && b_c)
                    m_pc = (m_pc + off) & 1023;
                else
                    m_pc = (m_pc + 1) & 1023;
            end
        end else if (s) begin
            m_st = 1; m_pc = a; m_cnt = 0;
        end
        e.pc   = m_pc;
        e.run  = (m_st == 1) ? 1 : 0;
        e.done = (m_st == 2) ? 1 : 0;
        e.cnt  = m_cnt;
        e.ins  = ins;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", int'(ifa.PC), e.pc);
                chk("pc_c4", int'(ifb.PC), e.pc);
                chk("running", int'(ifa.Running), e.run);
                chk("done", int'(ifa.Done), e.done);
                chk("cnt16", int'(ifa.InstrCount),
                    e.cnt > 65535 ? 65535 : e.cnt);
                chk("cnt4", int'(ifb.InstrCount),
                    e.cnt > 15 ? 15 : e.cnt);
                chk("typebit", int'(ifa.TypeBit),
                    e.run != 0 ? int'(e.ins[8]) : 0);
                chk("op", int'(ifa.OP),
                    e.run != 0 ? int'(e.ins[7:4]) : 15);
                chk("operand", int'(ifa.Operand), int'(e.ins[3:0]));
                chk("offset", int'(ifb.Offset), int'(e.ins[7:0]));
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < 1024; i++)
            rom[i] = {1'b0, 4'h3, 4'h0};
        rom[10'h014] = {1'b0, OP_HALT, 4'h0};
        rom[10'h020] = {1'b1, 8'hFC};
        rom[10'h3FE] = {1'b1, 8'h05};
        rom[10'h030] = {1'b1, 8'h00};
        rom[10'h040] = {1'b1, 8'h04};

        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        cyc(0, 1, 'h010, 0);
        repeat (7) cyc(0, 0, 0, 0);

        cyc(0, 1, 'h100, 0);
        repeat (3) cyc(0, 0, 0, 0);

        cyc(0, 1, 'h020, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 'h020, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        cyc(0, 1, 'h3FE, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 'h3FF, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        cyc(0, 1, 'h030, 1);
        repeat (3) cyc(0, 0, 0, 1);

        cyc(0, 1, 'h014, 0);
        cyc(0, 1, 'h014, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        cyc(0, 1, 'h040, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);

        cyc(0, 1, 'h200, 0);
        repeat (25) cyc(0, 0, 0, 0);

        cyc(0, 1, 'h05A, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        for (int i = 0; i < 1024; i++)
            rom[i] = 9'($urandom);
        repeat (400)
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 15) == 0,
                int'($urandom_range(0, 1023)),
                1'($urandom_range(0, 1)),
                $urandom_range(0, 31) == 0);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge CLK);
        #2;
        if (q.size() != 0)
            chk("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Upstream fetch/sequencing stage for the accumulator core. It owns the program counter and the run/halt state machine, and it addresses the external instruction ROM. It splits the returned 9-bit instruction into TypeBit, OP and operand fields for the control decoder. It takes back the decoder's Branch and Halt strobes, plus a branch condition from the datapath, to select the next PC.

Parameters:
PC_W, 10, program counter width in bits; instruction ROM depth is 2**PC_W
CNT_W, 16, width of the executed-instruction counter

Ports:
CLK  input  1  core clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  level-sampled request to (re)start execution at StartAddr
StartAddr  input  PC_W  program entry address, loaded when Start is accepted
Instr  input  9  instruction word from ROM at address PC (combinational ROM read)
Branch  input  1  from decoder: current instruction is a branch
Halt  input  1  from decoder: current instruction is halt
BranchCond  input  1  from datapath: branch condition true (accumulator LSB)
PC  output  PC_W  current instruction address to ROM
TypeBit  output  1  Instr[8] while running, else 0
OP  output  4  Instr[7:4] while running, else 4'hF (decoder no-op)
Operand  output  4  Instr[3:0] (register select / lookup key)
Offset  output  8  Instr[7:0], branch offset, two's complement
Running  output  1  state == RUN
Done  output  1  state == HALTED
InstrCount  output  CNT_W  instructions retired since last accepted Start

Behaviour:
- Reset (async, any time, including mid-program): state=IDLE, PC=0, InstrCount=0, Running=0, Done=0. Field outputs show TypeBit=0 and OP=4'hF.
- FSM states:
  - IDLE: on Start=1 at an edge, PC<=StartAddr, InstrCount<=0, go to RUN. Otherwise hold.
  - RUN: one instruction per cycle, zero fetch latency. PC drives the ROM, Instr returns the same cycle, and fields pass combinationally to the decoder.
  - HALTED: PC holds and Done=1. On Start=1, PC<=StartAddr, InstrCount<=0, go to RUN, and Done drops the next cycle.
- Next-PC priority in RUN, highest first, evaluated at each edge:
  1. Start=1: restart. PC<=StartAddr, InstrCount<=0, stay in RUN. The current instruction is not retired.
  2. Halt=1: go to HALTED, PC holds at the halt address, InstrCount+=1.
  3. Branch=1 and BranchCond=1: PC<=PC+sext(Offset) modulo 2**PC_W, InstrCount+=1.
  4. Otherwise, including a not-taken branch: PC<=PC+1 modulo 2**PC_W, InstrCount+=1.
- Arithmetic rules:
  - The offset is sign-extended from 8 bits to PC_W. The range is -128..+127 relative to the branch's own address.
  - Offset 0 is a legal self-loop.
  - PC wraps from 2**PC_W-1 to 0 without any flag.
- Halt and Branch both high is illegal from the decoder; Halt wins.
- InstrCount saturates at all-ones and does not wrap.
- Outside RUN, TypeBit=0 and OP=4'hF force the decoder to all-zero controls, so no register or memory writes occur. Branch and Halt inputs are ignored outside RUN.
- Start held high in RUN restarts every cycle. This is legal; the top level pulses Start for one cycle.

Decomposition:
- Shared package cpu_pkg:
  - PC_W
  - state enum {IDLE, RUN, HALTED}
  - opcode constants OP_HALT=4'd14 and OP_NOP=4'd15
  - instruction field positions: TYPE_BIT=8, OP_MSB=7, OP_LSB=4
- One natural sub-module, pc_next: combinational next-PC select (restart/hold/branch/increment with sign extension). The FSM and counter stay in instr_fetch.

Test Plan:
- Reset mid-RUN at PC=0x05A -> PC=0 and state IDLE asynchronously, before the next edge; OP=4'hF, Running=0.
- Start with StartAddr=0x010, ROM holds 4 non-branch instrs then halt -> PC sequence 0x010..0x014, then hold at 0x014. Done=1 the cycle after the halt edge; InstrCount=5.
- Branch at PC=0x020, Offset=8'hFC, BranchCond=1 -> next PC=0x01C. Same with BranchCond=0 -> next PC=0x021; InstrCount increments in both cases.
- Branch at PC=0x3FE, Offset=8'h05, taken -> PC wraps to 0x003. Sequential fetch at 0x3FF -> PC=0x000.
- Start pulse while HALTED at 0x014, StartAddr=0x100 -> Done drops, PC=0x100, InstrCount=0. Start and Halt together in RUN -> restart taken, no HALTED entry.
- Force InstrCount near max (CNT_W=4) -> counts to 15 and stays at 15 across further instructions.
